// File: rtl/gpio_cfg_regfile_pkg.sv
// Shared GPIO word layout, readback command offsets and sizing helpers.
// No logic; constants and constant functions only.
// Imported by the strobe synchroniser and the register bank.
package gpio_cfg_regfile_pkg;

    // Command offsets that follow the last config register (off = NUM_REGS + x).
    localparam int RD_SEL_OFS  = 0;
    localparam int RD_NEXT_OFS = 1;

    // The GPIO word is {w_clk, data, addr}; w_clk sits just above the data field.
    function automatic int gpio_w_clk_bit(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int gpio_data_lsb(input int addr_w);
        return addr_w;
    endfunction

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_strobe_sync.sv
// Synchronises the GPIO word into clk, arms after a real low w_clk sample, emits one-cycle strobe.
// Latency: strobe/addr/data registered, high in the cycle after edge k+SYNC_STAGES (w_clk sampled at k).
// No backpressure: software paces writes; at most one strobe per w_clk rising edge.
module gpio_strobe_sync
    import gpio_cfg_regfile_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W+DATA_W:0]   gpio_in,
    output logic                     strobe,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        data
);

    localparam int GW   = ADDR_W + DATA_W + 1;
    localparam int WCLK = gpio_w_clk_bit(ADDR_W, DATA_W);
    localparam int DLSB = gpio_data_lsb(ADDR_W);

    logic [GW-1:0]          sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;     // marks which stages hold real (post-reset) samples
    logic                   wclk_prev_q;
    logic                   armed_q;
    logic                   wclk_s;

    assign wclk_s = sync_q[SYNC_STAGES-1][WCLK];

    // Synchroniser chain, arm flag (only real low samples count) and registered edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            fill_q      <= '0;
            wclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            strobe      <= 1'b0;
            addr        <= '0;
            data        <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            wclk_prev_q <= wclk_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & ~wclk_s);
            strobe      <= wclk_s & ~wclk_prev_q & armed_q;
            addr        <= sync_q[SYNC_STAGES-1][ADDR_W-1:0];
            data        <= sync_q[SYNC_STAGES-1][WCLK-1:DLSB];
        end
    end

endmodule

// File: rtl/gpio_cfg_regfile.sv
// GPIO-to-register bridge: byte shift-in config bank, trigger pulses, byte-serial status readback.
// Latency: register/trig/count/err visible one edge after the strobe; readback byte 1 cycle behind.
// No backpressure: every strobe is accepted; bad offsets only set the sticky err_flag.
module gpio_cfg_regfile
    import gpio_cfg_regfile_pkg::*;
#(
    parameter int                    ADDR_W      = 16,
    parameter int                    DATA_W      = 8,
    parameter int                    NUM_REGS    = 32,
    parameter int                    REG_W       = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR   = '0,
    parameter logic [NUM_REGS-1:0]   PULSE_MASK  = '0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W+DATA_W:0]     gpio_in,
    output logic [NUM_REGS*REG_W-1:0]  reg_out,
    output logic [NUM_REGS-1:0]        trig_out,
    input  logic [NUM_REGS*REG_W-1:0]  rd_data_in,
    output logic [DATA_W-1:0]          gpio_rd_out,
    output logic [15:0]                wr_count,
    output logic                       err_flag
);

    localparam int NBYTES = REG_W / DATA_W;
    localparam int BYTE_W = clog2_min1(NBYTES);
    localparam int IDX_W  = clog2_min1(NUM_REGS);

    localparam logic [ADDR_W:0]  NREG_A    = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0]  RD_SEL_A  = (ADDR_W+1)'(NUM_REGS + RD_SEL_OFS);
    localparam logic [ADDR_W:0]  RD_NEXT_A = (ADDR_W+1)'(NUM_REGS + RD_NEXT_OFS);
    localparam logic [BYTE_W-1:0] MS_BYTE  = BYTE_W'(NBYTES - 1);

    logic              strobe;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W:0]   off_x;
    logic              in_range;

    logic [REG_W-1:0]  regs [NUM_REGS];
    logic [IDX_W-1:0]  rd_idx;
    logic [BYTE_W-1:0] rd_byte;

    gpio_strobe_sync #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .gpio_in (gpio_in),
        .strobe  (strobe),
        .addr    (addr),
        .data    (data)
    );

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign off_x    = {1'b0, addr - BASE_ADDR};
    assign in_range = (off_x < NREG_A);

    // Config bank: MSB-first byte shift-in, plus masked one-cycle trigger pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            trig_out <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                trig_out[i] <= 1'b0;
                if (strobe && in_range && off_x == (ADDR_W+1)'(i)) begin
                    regs[i]     <= REG_W'({regs[i], data});
                    trig_out[i] <= PULSE_MASK[i];
                end
            end
        end
    end

    // Write counter, sticky error and readback cursor.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
            err_flag <= 1'b0;
            rd_idx   <= '0;
            rd_byte  <= MS_BYTE;
        end else if (strobe) begin
            wr_count <= wr_count + 16'd1;
            if (off_x == RD_SEL_A) begin
                rd_idx  <= IDX_W'(32'(data) % NUM_REGS);
                rd_byte <= MS_BYTE;
            end else if (off_x == RD_NEXT_A) begin
                rd_byte <= (rd_byte == '0) ? MS_BYTE : rd_byte - BYTE_W'(1);
            end else if (!in_range) begin
                err_flag <= 1'b1;
            end
        end
    end

    // Readback byte re-sampled every cycle so live status is tracked.
    always_ff @(posedge clk) begin
        if (rst) gpio_rd_out <= '0;
        else     gpio_rd_out <= rd_data_in[32'(rd_idx)*REG_W + 32'(rd_byte)*DATA_W +: DATA_W];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*REG_W +: REG_W] = regs[g];
    end

endmodule

// File: tb/tb_gpio_cfg_regfile.sv
module tb_gpio_cfg_regfile;

    localparam int              ADDR_W   = 16;
    localparam int              DATA_W   = 8;
    localparam int              NUM_REGS = 32;
    localparam int              REG_W    = 32;
    localparam int              SYNC     = 2;
    localparam logic [15:0]     BASE     = 16'h0010;
    localparam logic [31:0]     PMASK    = 32'h0000_0001;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [ADDR_W+DATA_W:0]     gpio_in = '0;
    logic [NUM_REGS*REG_W-1:0]  reg_out;
    logic [NUM_REGS-1:0]        trig_out;
    logic [NUM_REGS*REG_W-1:0]  rd_data_in = '0;
    logic [DATA_W-1:0]          gpio_rd_out;
    logic [15:0]                wr_count;
    logic                       err_flag;

    gpio_cfg_regfile #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .NUM_REGS (NUM_REGS), .REG_W (REG_W),
        .BASE_ADDR (BASE), .PULSE_MASK (PMASK), .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk), .rst (rst), .gpio_in (gpio_in), .reg_out (reg_out),
        .trig_out (trig_out), .rd_data_in (rd_data_in), .gpio_rd_out (gpio_rd_out),
        .wr_count (wr_count), .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [31:0]  sb [$];
    logic [31:0]  exp, obs;
    logic [31:0]  mdl_regs [NUM_REGS];
    logic [15:0]  mdl_cnt;

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) mdl_regs[i] = '0;
        mdl_cnt = '0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        logic [15:0] off;
        off = a - BASE;
        if (off < 16'(NUM_REGS)) mdl_regs[off] = {mdl_regs[off][23:0], d};
        mdl_cnt = mdl_cnt + 16'd1;
    endtask

    // Full GPIO write handshake; counts cycles with any trigger asserted.
    task automatic gpio_write(input logic [15:0] a, input logic [7:0] d,
                              output int tcyc, output logic [31:0] tbits);
        tcyc = 0; tbits = '0;
        for (int i = 0; i < 2*SYNC + 8; i++) begin
            if (i < 2)                 gpio_in = {1'b0, d, a};
            else if (i < SYNC + 6)     gpio_in = {1'b1, d, a};
            else                       gpio_in = {1'b0, d, a};
            @(negedge clk);
            if (trig_out != '0) begin tcyc++; tbits |= trig_out; end
        end
        model_write(a, d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gpio_in = {1'b1, 8'h5A, BASE + 16'd3};
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (8) @(negedge clk);
        sb.push_back(32'(mdl_cnt));
        n_checks++; exp = sb.pop_front(); obs = 32'(wr_count);
        if (obs !== exp) $display("FAIL reset_wr_count: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = 32'(|reg_out);
        if (obs !== exp) $display("FAIL reset_reg_out_nonzero: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = {trig_out};
        if (obs !== exp) $display("FAIL reset_trig: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = {31'd0, err_flag};
        if (obs !== exp) $display("FAIL reset_err: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = 32'(gpio_rd_out);
        if (obs !== exp) $display("FAIL reset_rd_out: got %0h want %0h", obs, exp); else n_pass++;
        gpio_in = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_timing();
        gpio_in = {1'b0, 8'hAB, BASE + 16'd3};
        repeat (3) @(negedge clk);
        gpio_in = {1'b1, 8'hAB, BASE + 16'd3};
        repeat (SYNC + 1) @(negedge clk);
        sb.push_back(32'h0);
        n_checks++; exp = sb.pop_front(); obs = reg_out[3*REG_W +: REG_W];
        if (obs !== exp) $display("FAIL timing_early: got %0h want %0h", obs, exp); else n_pass++;
        @(negedge clk);
        model_write(BASE + 16'd3, 8'hAB);
        sb.push_back(mdl_regs[3]);
        n_checks++; exp = sb.pop_front(); obs = reg_out[3*REG_W +: REG_W];
        if (obs !== exp) $display("FAIL timing_reg3: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'(mdl_cnt));
        n_checks++; exp = sb.pop_front(); obs = 32'(wr_count);
        if (obs !== exp) $display("FAIL timing_wr_count: got %0h want %0h", obs, exp); else n_pass++;
        gpio_in = {1'b0, 8'hAB, BASE + 16'd3};
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic test_shift_in();
        int tc; logic [31:0] tb;
        logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        foreach (bytes[i]) gpio_write(BASE + 16'd5, bytes[i], tc, tb);
        sb.push_back(32'h1234_5678);
        n_checks++; exp = sb.pop_front(); obs = reg_out[5*REG_W +: REG_W];
        if (obs !== exp) $display("FAIL shift_reg5: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'(mdl_cnt));
        n_checks++; exp = sb.pop_front(); obs = 32'(wr_count);
        if (obs !== exp) $display("FAIL shift_wr_count: got %0h want %0h", obs, exp); else n_pass++;
    endtask

    task automatic test_trigger();
        int tc; logic [31:0] tb;
        gpio_in = {1'b0, 8'hC3, BASE};
        repeat (3) @(negedge clk);
        gpio_in = {1'b1, 8'hC3, BASE};
        repeat (SYNC + 1) @(negedge clk);
        sb.push_back(32'h0);
        n_checks++; exp = sb.pop_front(); obs = trig_out;
        if (obs !== exp) $display("FAIL trig_early: got %0h want %0h", obs, exp); else n_pass++;
        @(negedge clk);
        sb.push_back(32'h1);
        n_checks++; exp = sb.pop_front(); obs = trig_out;
        if (obs !== exp) $display("FAIL trig_pulse: got %0h want %0h", obs, exp); else n_pass++;
        @(negedge clk);
        sb.push_back(32'h0);
        n_checks++; exp = sb.pop_front(); obs = trig_out;
        if (obs !== exp) $display("FAIL trig_one_cycle: got %0h want %0h", obs, exp); else n_pass++;
        gpio_in = {1'b0, 8'hC3, BASE};
        repeat (SYNC + 3) @(negedge clk);
        model_write(BASE, 8'hC3);
        gpio_write(BASE + 16'd1, 8'h99, tc, tb);
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = 32'(tc);
        if (obs !== exp) $display("FAIL trig_unmasked_pulses: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(mdl_regs[1]);
        n_checks++; exp = sb.pop_front(); obs = reg_out[1*REG_W +: REG_W];
        if (obs !== exp) $display("FAIL trig_reg1: got %0h want %0h", obs, exp); else n_pass++;
    endtask

    task automatic test_readback();
        int tc; logic [31:0] tb;
        logic [7:0] seq [4] = '{8'hAD, 8'hBE, 8'hEF, 8'hDE};
        rd_data_in[7*REG_W +: REG_W] = 32'hDEAD_BEEF;
        gpio_write(BASE + 16'(NUM_REGS), 8'd7, tc, tb);
        sb.push_back(32'hDE);
        n_checks++; exp = sb.pop_front(); obs = 32'(gpio_rd_out);
        if (obs !== exp) $display("FAIL rd_sel: got %0h want %0h", obs, exp); else n_pass++;
        foreach (seq[i]) begin
            gpio_write(BASE + 16'(NUM_REGS + 1), 8'h00, tc, tb);
            sb.push_back(32'(seq[i]));
            n_checks++; exp = sb.pop_front(); obs = 32'(gpio_rd_out);
            if (obs !== exp) $display("FAIL rd_next_%0d: got %0h want %0h", i, obs, exp); else n_pass++;
        end
        rd_data_in[7*REG_W +: REG_W] = 32'hCAFE_F00D;
        sb.push_back(32'hCA);
        @(negedge clk);
        n_checks++; exp = sb.pop_front(); obs = 32'(gpio_rd_out);
        if (obs !== exp) $display("FAIL rd_live: got %0h want %0h", obs, exp); else n_pass++;
        gpio_write(BASE + 16'(NUM_REGS + 1), 8'h00, tc, tb);
        gpio_write(BASE + 16'(NUM_REGS), 8'd39, tc, tb);
        sb.push_back(32'hCA);
        n_checks++; exp = sb.pop_front(); obs = 32'(gpio_rd_out);
        if (obs !== exp) $display("FAIL rd_sel_mod: got %0h want %0h", obs, exp); else n_pass++;
    endtask

    task automatic test_error();
        int tc; logic [31:0] tb;
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = {31'd0, err_flag};
        if (obs !== exp) $display("FAIL err_before: got %0h want %0h", obs, exp); else n_pass++;
        gpio_write(BASE + 16'(NUM_REGS + 2), 8'hEE, tc, tb);
        sb.push_back(32'd1);
        n_checks++; exp = sb.pop_front(); obs = {31'd0, err_flag};
        if (obs !== exp) $display("FAIL err_above: got %0h want %0h", obs, exp); else n_pass++;
        gpio_write(16'h0005, 8'hEF, tc, tb);
        sb.push_back(32'd1);
        n_checks++; exp = sb.pop_front(); obs = {31'd0, err_flag};
        if (obs !== exp) $display("FAIL err_below: got %0h want %0h", obs, exp); else n_pass++;
        for (int i = 0; i < NUM_REGS; i++) begin
            sb.push_back(mdl_regs[i]);
            n_checks++; exp = sb.pop_front(); obs = reg_out[i*REG_W +: REG_W];
            if (obs !== exp) $display("FAIL err_bank_reg%0d: got %0h want %0h", i, obs, exp); else n_pass++;
        end
        sb.push_back(32'(mdl_cnt));
        n_checks++; exp = sb.pop_front(); obs = 32'(wr_count);
        if (obs !== exp) $display("FAIL err_wr_count: got %0h want %0h", obs, exp); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int tc; logic [31:0] tb;
        gpio_in = {1'b0, 8'h77, BASE + 16'd4};
        repeat (3) @(negedge clk);
        gpio_in = {1'b1, 8'h77, BASE + 16'd4};
        repeat (SYNC) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (8) @(negedge clk);
        sb.push_back(32'(mdl_cnt));
        n_checks++; exp = sb.pop_front(); obs = 32'(wr_count);
        if (obs !== exp) $display("FAIL rstmid_wr_count: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = 32'(|reg_out);
        if (obs !== exp) $display("FAIL rstmid_reg_out_nonzero: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = {31'd0, err_flag};
        if (obs !== exp) $display("FAIL rstmid_err: got %0h want %0h", obs, exp); else n_pass++;
        sb.push_back(32'd0);
        n_checks++; exp = sb.pop_front(); obs = 32'(gpio_rd_out);
        if (obs !== exp) $display("FAIL rstmid_rd_out: got %0h want %0h", obs, exp); else n_pass++;
        gpio_write(BASE + 16'd2, 8'h55, tc, tb);
        sb.push_back(mdl_regs[2]);
        n_checks++; exp = sb.pop_front(); obs = reg_out[2*REG_W +: REG_W];
        if (obs !== exp) $display("FAIL rstmid_rewrite: got %0h want %0h", obs, exp); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_write_timing();
        test_shift_in();
        test_trigger();
        test_readback();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
